// File: rtl/audio_drain_pkg.sv
// audio_drain_pkg: shared types and constants for the audio FIFO drain block.
`timescale 1ns/1ps
package audio_drain_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int UCNT_W_DEF = 16;
  localparam int MIN_PERIOD = 4;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READ  = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Effective sample period: anything shorter than MIN_PERIOD is stretched,
  // so a READ/LATCH pair always fits inside one period.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] div);
    return (div < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : div;
  endfunction

endpackage

// File: rtl/audio_fifo_drain_if.sv
// audio_fifo_drain_if: read side of a normal-mode (non show-ahead) FIFO.
// master = the drain engine, slave = the FIFO.
`timescale 1ns/1ps
interface audio_fifo_drain_if #(
  parameter int DATA_W = 32
) ();
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic [DATA_W-1:0] fifo_q;

  modport master (output fifo_rdreq, input fifo_empty, input fifo_q);
  modport slave  (input fifo_rdreq, output fifo_empty, output fifo_q);
endinterface

// File: rtl/audio_rate_tick.sv
// audio_rate_tick: sample-period down-counter. Loads P-1 on load_i, counts
// down while run_i, ticks for one cycle at zero and reloads P-1, so ticks are
// exactly P run-cycles apart. div_freq_i is only looked at on (re)load.
`timescale 1ns/1ps
module audio_rate_tick
  import audio_drain_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] div_freq_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload;

  assign reload = eff_period(div_freq_i) - CNT_W'(1);
  assign tick_o = run_i && (cnt_q == '0);

  // Next count: load, wrap-on-tick, decrement, or freeze.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = reload;
    else if (run_i)
      cnt_d = (cnt_q == '0) ? reload : cnt_q - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_fifo_drain.sv
// audio_fifo_drain: pulls one stereo word from a normal-mode FIFO every
// sample period and presents it as left/right with a one-cycle strobe.
// Optional build macro AUDIO_DRAIN_FLUSH_EN: while stopped, empty the FIFO.
`timescale 1ns/1ps
module audio_fifo_drain
  import audio_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int UCNT_W = UCNT_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [31:0]         div_freq,
  input  logic                pause,
  input  logic                stop,
  input  logic                fifo_empty,
  output logic                fifo_rdreq,
  input  logic [DATA_W-1:0]   fifo_q,
  output logic [DATA_W/2-1:0] audio_left,
  output logic [DATA_W/2-1:0] audio_right,
  output logic                sample_valid,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  input  logic                underrun_clr
);

  localparam int HW = DATA_W / 2;

  state_t            state_q;
  logic              rdreq_q;
  logic [HW-1:0]     left_q, right_q;
  logic              sv_q;
  logic              ur_q;
  logic [UCNT_W-1:0] ucnt_q;

  logic tick, tick_load, tick_run, ur_evt;

  // Leaving IDLE arms the counter; pause only freezes it in WAIT so an
  // in-flight READ/LATCH always completes.
  assign tick_load = (state_q == IDLE) && !stop;
  assign tick_run  = !stop && ((state_q == READ) || (state_q == LATCH) ||
                               ((state_q == WAIT) && !pause));
  assign ur_evt    = (state_q == WAIT) && !stop && tick && fifo_empty;

  audio_rate_tick u_tick (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .load_i     (tick_load),
    .run_i      (tick_run),
    .div_freq_i (div_freq),
    .tick_o     (tick)
  );

  // Main FSM with registered rdreq and sample outputs; stop wins over all.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      rdreq_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      sv_q    <= 1'b0;
    end else if (stop && (state_q != IDLE)) begin
      // A word popped in READ is simply never latched.
      state_q <= IDLE;
      rdreq_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      sv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          left_q  <= '0;
          right_q <= '0;
          sv_q    <= 1'b0;
`ifdef AUDIO_DRAIN_FLUSH_EN
          rdreq_q <= stop && !fifo_empty;
`else
          rdreq_q <= 1'b0;
`endif
          if (!stop) state_q <= WAIT;
        end
        WAIT: begin
          sv_q <= 1'b0;
          if (tick && !fifo_empty) begin
            rdreq_q <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          rdreq_q <= 1'b0;
          state_q <= LATCH;
        end
        LATCH: begin
          // fifo_q is valid here, one cycle after the rdreq cycle.
          left_q  <= fifo_q[DATA_W-1:HW];
          right_q <= fifo_q[HW-1:0];
          sv_q    <= 1'b1;
          state_q <= WAIT;
        end
      endcase
    end
  end

  // Sticky underrun flag and saturating count; a clear coincident with an
  // event clears first, then counts that event.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ur_q   <= 1'b0;
      ucnt_q <= '0;
    end else if (underrun_clr) begin
      ur_q   <= ur_evt;
      ucnt_q <= ur_evt ? UCNT_W'(1) : '0;
    end else if (ur_evt) begin
      ur_q <= 1'b1;
      if (!(&ucnt_q)) ucnt_q <= ucnt_q + UCNT_W'(1);
    end
  end

  assign fifo_rdreq   = rdreq_q;
  assign audio_left   = left_q;
  assign audio_right  = right_q;
  assign sample_valid = sv_q;
  assign underrun     = ur_q;
  assign underrun_cnt = ucnt_q;

endmodule
